// File: rtl/sprite_ram_loader.sv
// rtl/sprite_ram_loader.sv - sprite RAM write engine: pointer writes with auto-increment and hardware fill
// Optional build macro: SPRITE_LOADER_RLE_EN (DATA writes carry a run length; runs > 1 behave as a fill)
module sprite_ram_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  write,
  input  logic                  read,
  input  logic [4:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [4:0] REG_PTR    = 5'd0;
  localparam logic [4:0] REG_DATA   = 5'd1;
  localparam logic [4:0] REG_LEN    = 5'd2;
  localparam logic [4:0] REG_FILL   = 5'd3;
  localparam logic [4:0] REG_STATUS = 5'd4;

`ifdef SPRITE_LOADER_RLE_EN
  localparam logic RLE_BUILD = 1'b1;
`else
  localparam logic RLE_BUILD = 1'b0;
`endif

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] colour_q, colour_d;
  logic                  overrun_q, overrun_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic        wr_en;
  logic        busy;
  logic [31:0] status;
  logic        unused_inputs;

  assign wr_en = cs & write;
  assign busy  = (state_q == ST_FILL);

  // Reads have no side effects and only part of the write word is meaningful
  assign unused_inputs = ^{read, wr_data};

`ifdef SPRITE_LOADER_RLE_EN
  logic [7:0] run;
  assign run = wr_data[15:8];
`endif

  // Next-state logic: fill sequencing plus MMIO register writes (at most one access per cycle)
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    overrun_d = overrun_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;

    if (busy) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      din_d  = colour_q;
      ptr_d  = ptr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
        state_d = ST_IDLE;
      end
    end

    if (wr_en) begin
      case (reg_addr)
        REG_PTR: begin
          if (busy) overrun_d = 1'b1;
          else      ptr_d     = wr_data[ADDR_WIDTH-1:0];
        end
        REG_DATA: begin
          if (busy) begin
            overrun_d = 1'b1;
          end
`ifdef SPRITE_LOADER_RLE_EN
          else if (run > 8'd1) begin
            colour_d = wr_data[DATA_WIDTH-1:0];
            cnt_d    = (ADDR_WIDTH+1)'(run);
            state_d  = ST_FILL;
          end
`endif
          else begin
            we_d   = 1'b1;
            addr_d = ptr_q;
            din_d  = wr_data[DATA_WIDTH-1:0];
            ptr_d  = ptr_q + 1'b1;
          end
        end
        REG_LEN: begin
          len_d = wr_data[ADDR_WIDTH:0];
        end
        REG_FILL: begin
          if (busy) begin
            overrun_d = 1'b1;
          end else if (len_q != '0) begin
            colour_d = wr_data[DATA_WIDTH-1:0];
            cnt_d    = len_q;
            state_d  = ST_FILL;
          end
        end
        REG_STATUS: begin
          overrun_d = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // State and RAM-side output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      colour_q  <= '0;
      overrun_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      colour_q  <= colour_d;
      overrun_q <= overrun_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  // Combinational register read-back
  always_comb begin
    status                  = '0;
    status[0]               = busy;
    status[1]               = overrun_q;
    status[2]               = RLE_BUILD;
    status[16 +: ADDR_WIDTH] = ptr_q;
    case (reg_addr)
      REG_PTR:    rd_data = 32'(ptr_q);
      REG_LEN:    rd_data = 32'(len_q);
      REG_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

  assign ram_we     = we_q;
  assign ram_addr_w = addr_q;
  assign ram_din    = din_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb/tb_sprite_ram_loader.sv - randomized and directed bench for sprite_ram_loader against a write-schedule model
module tb_sprite_ram_loader;

  localparam int AW    = 11;
  localparam int DW    = 3;
  localparam int DEPTH = 1 << AW;

`ifdef SPRITE_LOADER_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cs;
  logic          write;
  logic          read;
  logic [4:0]    reg_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_din;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sprite_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .write      (write),
    .read       (read),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .ram_we     (ram_we),
    .ram_addr_w (ram_addr_w),
    .ram_din    (ram_din)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: every accepted command is turned into a schedule of RAM writes keyed by clock edge
  int exp_wr [int];
  int edge_n  = 0;
  int m_ptr   = 0;
  int m_len   = 0;
  int m_ovr   = 0;
  int fs      = -10;
  int flen    = 0;
  int fbase   = 0;
  bit m_valid = 1'b0;
  bit exp_we  = 1'b0;
  int exp_addr = 0;
  int exp_din  = 0;

  function automatic bit busy_at(int e);
    return (flen > 0) && (e >= fs) && (e < fs + flen);
  endfunction

  function automatic int ptr_at(int e);
    if (busy_at(e)) return (fbase + (e - fs)) % DEPTH;
    return m_ptr;
  endfunction

  function automatic void start_fill(int e, int len, int colour);
    fs    = e;
    flen  = len;
    fbase = m_ptr;
    for (int k = 1; k <= len; k++) exp_wr[e + k] = ((fbase + k - 1) % DEPTH) * 8 + colour;
    m_ptr = (fbase + len) % DEPTH;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int          p;
    p        = ptr_at(edge_n);
    s        = '0;
    s[0]     = busy_at(edge_n);
    s[1]     = (m_ovr != 0);
    s[2]     = RLE;
    s[26:16] = p[10:0];
    return s;
  endfunction

  // Model update at each rising edge, from the bus values the DUT samples there
  always @(posedge clk) begin
    bit busy_now;
    int run;
    edge_n++;
    if (!reset_n) begin
      for (int k = edge_n; k <= fs + flen; k++) if (exp_wr.exists(k)) exp_wr.delete(k);
      m_ptr = 0; m_len = 0; m_ovr = 0; flen = 0; fs = -10;
      exp_we = 1'b0; exp_addr = 0; exp_din = 0; m_valid = 1'b1;
    end else begin
      busy_now = busy_at(edge_n - 1);
      if (cs && write) begin
        case (reg_addr)
          5'd0: if (busy_now) m_ovr = 1; else m_ptr = int'(wr_data[10:0]);
          5'd1: begin
            run = RLE ? int'(wr_data[15:8]) : 0;
            if (busy_now) m_ovr = 1;
            else if (run > 1) start_fill(edge_n, run, int'(wr_data[2:0]));
            else begin
              exp_wr[edge_n] = m_ptr * 8 + int'(wr_data[2:0]);
              m_ptr = (m_ptr + 1) % DEPTH;
            end
          end
          5'd2: m_len = int'(wr_data[11:0]);
          5'd3: if (busy_now) m_ovr = 1; else if (m_len != 0) start_fill(edge_n, m_len, int'(wr_data[2:0]));
          5'd4: m_ovr = 0;
          default: ;
        endcase
      end
      exp_we = exp_wr.exists(edge_n);
      if (exp_we) begin
        exp_addr = exp_wr[edge_n] / 8;
        exp_din  = exp_wr[edge_n] % 8;
        exp_wr.delete(edge_n);
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("ram_we", 64'(ram_we), 64'(exp_we));
      check("ram_addr_w", 64'(ram_addr_w), 64'(exp_addr));
      check("ram_din", 64'(ram_din), 64'(exp_din));
      if (cs && read && !write && reg_addr == 5'd4) check("status", 64'(rd_data), 64'(exp_status()));
    end
  end

  task automatic idle_bus();
    cs = 1'b1; write = 1'b0; read = 1'b1; reg_addr = 5'd4; wr_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic op(input int r, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; reg_addr = r[4:0]; wr_data = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  int we_cnt, busy_cnt, first_addr, r;
  bit first;

  initial begin
    reset_n = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_status", 64'(rd_data), 64'(RLE ? 32'h4 : 32'h0));
    check("reset_we", 64'(ram_we), 64'd0);
    @(posedge clk); #1;

    // Pointer writes with auto-increment
    op(0, 32'd5); op(1, 32'd3); op(1, 32'd6);
    @(negedge clk);
    check("t1_ptr", 64'(rd_data[26:16]), 64'd7);
    check("t1_model_ptr", 64'(m_ptr), 64'd7);
    @(posedge clk); #1;

    // Pointer wrap
    op(0, 32'd2047); op(1, 32'd1); op(1, 32'd2);
    @(negedge clk);
    check("t2_ptr_wrap", 64'(rd_data[26:16]), 64'd1);
    @(posedge clk); #1;

    // 16-word fill
    op(0, 32'd100); op(2, 32'd16); op(3, 32'd4);
    we_cnt = 0; busy_cnt = 0; first = 1'b1; first_addr = -1;
    repeat (20) begin
      @(negedge clk);
      we_cnt   += int'(ram_we);
      busy_cnt += int'(rd_data[0]);
      if (ram_we && first) begin first = 1'b0; first_addr = int'(ram_addr_w); end
    end
    check("t3_we_cycles", 64'(we_cnt), 64'd16);
    check("t3_busy_cycles", 64'(busy_cnt), 64'd16);
    check("t3_first_addr", 64'(first_addr), 64'd100);
    check("t3_ptr", 64'(rd_data[26:16]), 64'd116);
    @(posedge clk); #1;

    // Zero-length fill is a no-op
    op(2, 32'd0); op(3, 32'd5);
    we_cnt = 0; busy_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      we_cnt   += int'(ram_we);
      busy_cnt += int'(rd_data[0]);
    end
    check("t4_len0_we", 64'(we_cnt), 64'd0);
    check("t4_len0_busy", 64'(busy_cnt), 64'd0);
    @(posedge clk); #1;

    // DATA during a fill is dropped and flags overrun; STATUS write clears it
    op(2, 32'd30); op(3, 32'd1); idle(2); op(1, 32'd7);
    @(negedge clk);
    check("t4_overrun_set", 64'(rd_data[1]), 64'd1);
    @(posedge clk); #1;
    idle(40);
    op(4, 32'd0);
    @(negedge clk);
    check("t4_overrun_clr", 64'(rd_data[1]), 64'd0);
    @(posedge clk); #1;

    // Reset during the 5th cycle of a 64-word fill
    op(2, 32'd64); op(3, 32'd2); idle(4);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_we_after_rst", 64'(ram_we), 64'd0);
    check("t5_busy_after_rst", 64'(rd_data[0]), 64'd0);
    check("t5_ptr_after_rst", 64'(rd_data[26:16]), 64'd0);
    we_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      we_cnt += int'(ram_we);
    end
    check("t5_no_writes", 64'(we_cnt), 64'd0);
    @(posedge clk); #1;

    // Fill longer than the RAM wraps around
    op(0, 32'd2040); op(2, 32'd2050); op(3, 32'd3);
    idle(2060);
    @(negedge clk);
    check("t6_long_fill_ptr", 64'(rd_data[26:16]), 64'd2042);
    @(posedge clk); #1;

    // Randomized command mix
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       op(0, $urandom);
      else if (r < 8)  op(1, $urandom);
      else if (r < 10) op(2, 32'($urandom_range(0, 24)));
      else if (r < 12) op(3, $urandom);
      else if (r < 14) op(4, $urandom);
      else if (r < 15) op($urandom_range(5, 31), $urandom);
      else if (r == 19 && $urandom_range(0, 7) == 0) apply_reset();
      else idle($urandom_range(1, 6));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
